// File: rtl/el2_ic_pkg.sv
// Shared types and constants for the I-cache fill/debug write path.
// ecc_mask() builds the per-check-bit data masks for the 64-bit Hamming SEC code.
package el2_ic_pkg;

    localparam int BEATS_PER_LINE = 8;
    localparam int ADDR_W         = 12;
    localparam int ECC_W          = 7;
    localparam int IC_WORD_W      = 71;
    localparam int LINE_OFF_W     = 6;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    // Data bits fill codeword positions 1..71 that are not powers of two.
    function automatic logic [63:0] ecc_mask(input int check_bit);
        logic [63:0] m;
        int          d;
        m = '0;
        d = 0;
        for (int p = 1; p < 72; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (((p >> check_bit) & 1) != 0) begin
                    m[d] = 1'b1;
                end
                d++;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/el2_ic_fill_wr_if.sv
// Request-side handshakes and array write port of the I-cache fill writer.
interface el2_ic_fill_wr_if;
    import el2_ic_pkg::*;

    logic                  io_miss_valid;
    logic                  io_miss_ready;
    logic [ADDR_W-1:0]     io_miss_addr;
    logic [1:0]            io_miss_way;
    logic                  io_beat_valid;
    logic                  io_beat_ready;
    logic [63:0]           io_beat_data;
    logic                  io_beat_err;
    logic                  io_dbg_wr_valid;
    logic                  io_dbg_wr_ready;
    logic [ADDR_W-1:0]     io_dbg_addr;
    logic [1:0]            io_dbg_way;
    logic [IC_WORD_W-1:0]  io_dbg_data;
    logic [ADDR_W-1:0]     io_ic_rw_addr;
    logic [1:0]            io_ic_wr_en;
    logic [1:0]            io_ic_wr_bank;
    logic [IC_WORD_W-1:0]  io_ic_wr_data_0;
    logic [IC_WORD_W-1:0]  io_ic_wr_data_1;
    logic                  io_fill_done;
    logic                  io_fill_err;
    logic                  io_busy;

    modport slave (
        input  io_miss_valid, io_miss_addr, io_miss_way,
        input  io_beat_valid, io_beat_data, io_beat_err,
        input  io_dbg_wr_valid, io_dbg_addr, io_dbg_way, io_dbg_data,
        output io_miss_ready, io_beat_ready, io_dbg_wr_ready,
        output io_ic_rw_addr, io_ic_wr_en, io_ic_wr_bank,
        output io_ic_wr_data_0, io_ic_wr_data_1,
        output io_fill_done, io_fill_err, io_busy
    );

    modport master (
        output io_miss_valid, io_miss_addr, io_miss_way,
        output io_beat_valid, io_beat_data, io_beat_err,
        output io_dbg_wr_valid, io_dbg_addr, io_dbg_way, io_dbg_data,
        input  io_miss_ready, io_beat_ready, io_dbg_wr_ready,
        input  io_ic_rw_addr, io_ic_wr_en, io_ic_wr_bank,
        input  io_ic_wr_data_0, io_ic_wr_data_1,
        input  io_fill_done, io_fill_err, io_busy
    );

endinterface

// File: rtl/el2_ic_ecc_gen.sv
// Combinational 7-bit Hamming SEC check-bit generator for one 64-bit beat.
module el2_ic_ecc_gen
    import el2_ic_pkg::*;
(
    input  logic [63:0]      data_i,
    output logic [ECC_W-1:0] ecc_o
);

    for (genvar i = 0; i < ECC_W; i++) begin : g_chk
        localparam logic [63:0] MASK = ecc_mask(i);
        assign ecc_o[i] = ^(data_i & MASK);
    end

endmodule

// File: rtl/el2_ic_fill_wr.sv
// I-cache data-array write initiator: packs fill beats into ECC-protected
// even/odd bank pairs and forwards raw debug writes.
//
// state | meaning
// IDLE  | accepting a miss or a debug write; miss wins a collision
// FILL  | draining 8 beats, writing each even/odd pair unless the line errored
module el2_ic_fill_wr
    import el2_ic_pkg::*;
(
    input logic             clock,
    input logic             io_rst_l,
    el2_ic_fill_wr_if.slave bus
);

    state_t                state_q, state_d;
    logic [2:0]            cnt_q, cnt_d;
    logic                  err_q, err_d;
    logic [5:0]            line_q, line_d;
    logic [1:0]            way_q, way_d;
    logic [63:0]           even_q, even_d;
    logic [ADDR_W-1:0]     rw_addr_q, rw_addr_d;
    logic [1:0]            wr_en_q, wr_en_d;
    logic [1:0]            wr_bank_q, wr_bank_d;
    logic [IC_WORD_W-1:0]  wd0_q, wd0_d;
    logic [IC_WORD_W-1:0]  wd1_q, wd1_d;
    logic                  done_q, done_d;
    logic                  ferr_q, ferr_d;

    logic                  miss_ready, beat_ready, dbg_ready;
    logic                  line_err;
    logic [ECC_W-1:0]      ecc_even, ecc_odd;

    // The even beat is held raw; its check bits are formed when the pair goes out.
    el2_ic_ecc_gen u_ecc_even (.data_i(even_q),           .ecc_o(ecc_even));
    el2_ic_ecc_gen u_ecc_odd  (.data_i(bus.io_beat_data), .ecc_o(ecc_odd));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        line_d     = line_q;
        way_d      = way_q;
        even_d     = even_q;
        rw_addr_d  = rw_addr_q;
        wr_en_d    = 2'b00;
        wr_bank_d  = 2'b00;
        wd0_d      = wd0_q;
        wd1_d      = wd1_q;
        done_d     = 1'b0;
        ferr_d     = 1'b0;
        miss_ready = 1'b0;
        beat_ready = 1'b0;
        dbg_ready  = 1'b0;
        line_err   = err_q;

        case (state_q)
            IDLE: begin
                miss_ready = 1'b1;
                dbg_ready  = !bus.io_miss_valid;
                if (bus.io_miss_valid) begin
                    line_d  = bus.io_miss_addr[ADDR_W-1:LINE_OFF_W];
                    way_d   = bus.io_miss_way;
                    cnt_d   = 3'd0;
                    err_d   = 1'b0;
                    state_d = FILL;
                end else if (bus.io_dbg_wr_valid) begin
                    wr_en_d   = bus.io_dbg_way;
                    rw_addr_d = bus.io_dbg_addr;
                    wr_bank_d = bus.io_dbg_addr[3] ? 2'b10 : 2'b01;
                    wd0_d     = bus.io_dbg_data;
                    wd1_d     = bus.io_dbg_data;
                end
            end
            FILL: begin
                beat_ready = 1'b1;
                if (bus.io_beat_valid) begin
                    line_err = err_q | bus.io_beat_err;
                    err_d    = line_err;
                    cnt_d    = cnt_q + 3'd1;
                    if (!cnt_q[0]) begin
                        even_d = bus.io_beat_data;
                    end else if (!line_err && (way_q != 2'b00)) begin
                        wr_en_d   = way_q;
                        wr_bank_d = 2'b11;
                        rw_addr_d = {line_q, cnt_q[2:1], 4'b0000};
                        wd0_d     = {ecc_even, even_q};
                        wd1_d     = {ecc_odd, bus.io_beat_data};
                    end
                    if (cnt_q == 3'(BEATS_PER_LINE - 1)) begin
                        state_d = IDLE;
                        done_d  = !line_err;
                        ferr_d  = line_err;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!io_rst_l) begin
            state_q   <= IDLE;
            cnt_q     <= 3'd0;
            err_q     <= 1'b0;
            line_q    <= '0;
            way_q     <= 2'b00;
            even_q    <= '0;
            rw_addr_q <= '0;
            wr_en_q   <= 2'b00;
            wr_bank_q <= 2'b00;
            wd0_q     <= '0;
            wd1_q     <= '0;
            done_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            line_q    <= line_d;
            way_q     <= way_d;
            even_q    <= even_d;
            rw_addr_q <= rw_addr_d;
            wr_en_q   <= wr_en_d;
            wr_bank_q <= wr_bank_d;
            wd0_q     <= wd0_d;
            wd1_q     <= wd1_d;
            done_q    <= done_d;
            ferr_q    <= ferr_d;
        end
    end

    assign bus.io_miss_ready   = miss_ready;
    assign bus.io_beat_ready   = beat_ready;
    assign bus.io_dbg_wr_ready = dbg_ready;
    assign bus.io_ic_rw_addr   = rw_addr_q;
    assign bus.io_ic_wr_en     = wr_en_q;
    assign bus.io_ic_wr_bank   = wr_bank_q;
    assign bus.io_ic_wr_data_0 = wd0_q;
    assign bus.io_ic_wr_data_1 = wd1_q;
    assign bus.io_fill_done    = done_q;
    assign bus.io_fill_err     = ferr_q;
    assign bus.io_busy         = (state_q != IDLE);

endmodule
